neuron_array_wb: RTL and testbench

NEURON_ARRAY_WB -- requirements
Module: neuron_array_wb

---
 rtl/neuron_array_wb.sv | 236 +++++++++++++++++++++++
 tb/tb_neuron_array_wb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_array_wb.sv
// Wishbone-mapped array of leaky integrate-and-fire neurons fed by an event FIFO.
// Queued events integrate into membrane potentials; a tick leaks every neuron and fires those over threshold.
module neuron_array_wb #(
    parameter int          NUM_NEURONS = 16,
    parameter int          POT_W       = 16,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq
);

    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int EV_W  = 8 + POT_W;
    localparam logic signed [POT_W-1:0] POT_MAX = {1'b0, {(POT_W-1){1'b1}}};
    localparam logic signed [POT_W-1:0] POT_MIN = {1'b1, {(POT_W-1){1'b0}}};
    localparam logic [7:0]       NN8       = 8'(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_NEURONS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, INTEG, LEAK_FIRE, CLEAR} state_t;

    function automatic logic signed [POT_W-1:0] sat_add(input logic signed [POT_W-1:0] a,
                                                        input logic signed [POT_W-1:0] b);
        logic signed [POT_W:0] s;
        s = {a[POT_W-1], a} + {b[POT_W-1], b};
        if (s[POT_W] != s[POT_W-1]) return s[POT_W] ? POT_MIN : POT_MAX;
        return s[POT_W-1:0];
    endfunction

    // Leak is unsigned, so only underflow can occur; two guard bits cover the full range.
    function automatic logic signed [POT_W-1:0] sat_sub_leak(input logic signed [POT_W-1:0] v,
                                                             input logic [POT_W-1:0] lk);
        logic signed [POT_W+1:0] d;
        d = {{2{v[POT_W-1]}}, v} - {2'b00, lk};
        if (d[POT_W+1:POT_W-1] != 3'b000 && d[POT_W+1:POT_W-1] != 3'b111) return POT_MIN;
        return d[POT_W-1:0];
    endfunction

    function automatic logic [31:0] apply_sel(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return r;
    endfunction

    state_t state, state_nxt;
    logic enable, irq_en, tick_pend, clear_pend, overflow;
    logic signed [POT_W-1:0] thresh;
    logic [POT_W-1:0]        leak;
    logic signed [POT_W-1:0] pot [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]  spike_out;
    logic [IDX_W-1:0]        lf_idx;

    logic [EV_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic full, empty, push, pop, fifo_last;

    logic hit, access, wr, rd, pot_valid, busy, enter_lf;
    logic [9:0]  word;
    logic [5:0]  pot_rd_idx;
    logic [31:0] rdata, thresh_wr, leak_wr;
    logic wr_ctrl, wr_status, wr_event, wr_thresh, wr_leak, ev_push_req, tick_req, clear_req;

    logic [EV_W-1:0]         ev_head;
    logic [7:0]              ev_idx;
    logic signed [POT_W-1:0] ev_w;
    logic signed [POT_W-1:0] lf_v;
    logic                    lf_fire;
    logic                    unused_bits;

    assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign access     = hit & ~wbs_ack_o;
    assign wr         = access & wbs_we_i;
    assign rd         = access & ~wbs_we_i;
    assign word       = wbs_adr_i[11:2];
    assign pot_rd_idx = word[5:0];
    assign pot_valid  = (word[9:6] == 4'b0001) && ({2'b00, pot_rd_idx} < NN8);

    assign wr_ctrl     = wr && (word == 10'd0);
    assign wr_status   = wr && (word == 10'd1);
    assign wr_event    = wr && (word == 10'd2);
    assign wr_thresh   = wr && (word == 10'd3);
    assign wr_leak     = wr && (word == 10'd4);
    assign ev_push_req = wr_event && (wbs_sel_i == 4'hF);
    assign tick_req    = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[1];
    assign clear_req   = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[2];
    assign thresh_wr   = apply_sel(32'(thresh), wbs_dat_i, wbs_sel_i);
    assign leak_wr     = apply_sel(32'(leak), wbs_dat_i, wbs_sel_i);
    assign unused_bits = ^{wbs_adr_i[1:0], thresh_wr[31:POT_W], leak_wr[31:POT_W]};

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign push      = ev_push_req && !full;
    assign pop       = (state == INTEG) && !empty;
    // The pop of the final entry ends integration in the same cycle, keeping ticks tight.
    assign fifo_last = empty || ((count == CNT_W'(1)) && !push);

    assign ev_head = fifo_mem[rd_ptr];
    assign ev_idx  = ev_head[7:0];
    assign ev_w    = ev_head[EV_W-1:8];

    assign lf_v    = sat_sub_leak(pot[lf_idx], leak);
    assign lf_fire = (lf_v >= thresh);

    assign busy     = (state != IDLE);
    assign enter_lf = (state != LEAK_FIRE) && (state_nxt == LEAK_FIRE);
    assign irq      = irq_en & (|spike_out);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    if (clear_pend)     state_nxt = CLEAR;
                    else if (!empty)    state_nxt = INTEG;
                    else if (tick_pend) state_nxt = LEAK_FIRE;
                end
            end
            INTEG:     if (fifo_last) state_nxt = tick_pend ? LEAK_FIRE : IDLE;
            LEAK_FIRE: if (lf_idx == LAST_IDX) state_nxt = IDLE;
            CLEAR:     state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (word)
            10'd0:   rdata = {28'd0, irq_en, 2'b00, enable};
            10'd1:   rdata = {16'd0, 8'(count), 4'd0, overflow, empty, full, busy};
            10'd3:   rdata = 32'(thresh);
            10'd4:   rdata = 32'(leak);
            10'd5:   rdata = 32'(spike_out);
            default: if (pot_valid) rdata = 32'(pot[pot_rd_idx[IDX_W-1:0]]);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= access;
            wbs_dat_o <= rd ? rdata : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            enable     <= 1'b0;
            irq_en     <= 1'b0;
            tick_pend  <= 1'b0;
            clear_pend <= 1'b0;
            overflow   <= 1'b0;
            thresh     <= POT_MAX;
            leak       <= '0;
            lf_idx     <= '0;
        end else begin
            state <= state_nxt;
            if (wr_ctrl && wbs_sel_i[0]) begin
                enable <= wbs_dat_i[0];
                irq_en <= wbs_dat_i[3];
            end
            if (tick_req)      tick_pend <= 1'b1;
            else if (enter_lf) tick_pend <= 1'b0;
            if (clear_req)                                         clear_pend <= 1'b1;
            else if (state == IDLE && state_nxt == CLEAR)          clear_pend <= 1'b0;
            if (ev_push_req && full)                               overflow <= 1'b1;
            else if (wr_status && wbs_sel_i[0] && wbs_dat_i[3])    overflow <= 1'b0;
            if (wr_thresh) thresh <= thresh_wr[POT_W-1:0];
            if (wr_leak)   leak   <= leak_wr[POT_W-1:0];
            if (enter_lf)                lf_idx <= '0;
            else if (state == LEAK_FIRE) lf_idx <= (lf_idx == LAST_IDX) ? '0 : lf_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= wbs_dat_i[EV_W-1:0];
    end

    // Potentials and spikes: integrate in INTEG, leak/fire one neuron per cycle, wipe in CLEAR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) pot[i] <= '0;
            spike_out <= '0;
        end else begin
            case (state)
                INTEG: begin
                    if (pop && (ev_idx < NN8))
                        pot[ev_idx[IDX_W-1:0]] <= sat_add(pot[ev_idx[IDX_W-1:0]], ev_w);
                end
                LEAK_FIRE: begin
                    pot[lf_idx]       <= lf_fire ? '0 : lf_v;
                    spike_out[lf_idx] <= lf_fire;
                end
                CLEAR: begin
                    for (int i = 0; i < NUM_NEURONS; i++) pot[i] <= '0;
                    spike_out <= '0;
                end
                default: ;
            endcase
            if (enter_lf) spike_out <= '0;
        end
    end

endmodule

// File: tb/tb_neuron_array_wb.sv
// Directed bench for neuron_array_wb: register access, integration, leak/fire, FIFO limits and reset.
module tb_neuron_array_wb;

    localparam int          NN    = 16;
    localparam int          PW    = 16;
    localparam int          FD    = 8;
    localparam logic [31:0] BASE  = 32'h3000_0000;

    localparam logic [11:0] R_CTRL   = 12'h000;
    localparam logic [11:0] R_STATUS = 12'h004;
    localparam logic [11:0] R_EVENT  = 12'h008;
    localparam logic [11:0] R_THRESH = 12'h00C;
    localparam logic [11:0] R_LEAK   = 12'h010;
    localparam logic [11:0] R_SPIKE  = 12'h014;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    int busy_total = 0;

    always #5 clk = ~clk;

    neuron_array_wb #(
        .NUM_NEURONS(NN), .POT_W(PW), .FIFO_DEPTH(FD), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o), .irq(irq)
    );

    always @(posedge clk) if (dut.busy) busy_total <= busy_total + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [11:0] off, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = BASE | 32'(off); wdat = d; sel = s;
        check("ack_before_edge", {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        check("ack_one_cycle", {31'd0, ack}, 32'd1);
        r = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_wr(input logic [11:0] off, input logic [31:0] d);
        logic [31:0] r;
        wb_xfer(1'b1, off, d, 4'hF, r);
    endtask

    task automatic rd_check(input string tag, input logic [11:0] off, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(1'b0, off, 32'd0, 4'hF, r);
        check(tag, r, exp);
    endtask

    task automatic wait_idle();
        logic [31:0] r;
        int n = 0;
        do begin
            wb_xfer(1'b0, R_STATUS, 32'd0, 4'hF, r);
            n++;
        end while (r[0] && n < 200);
        check("idle_reached", {31'd0, r[0]}, 32'd0);
    endtask

    function automatic logic [31:0] ev(input int idx, input int w);
        return {8'd0, 16'(w), 8'(idx)};
    endfunction

    function automatic logic [11:0] pot_off(input int i);
        return 12'(12'h100 + 4 * i);
    endfunction

    initial begin
        int b0;
        logic [31:0] r;

        repeat (2) @(posedge clk); #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b1;
        rd_check("rst_ctrl",   R_CTRL,   32'h0000_0000);
        rd_check("rst_status", R_STATUS, 32'h0000_0004);
        rd_check("rst_thresh", R_THRESH, 32'h0000_7FFF);
        rd_check("rst_leak",   R_LEAK,   32'h0000_0000);
        rd_check("rst_spike",  R_SPIKE,  32'h0000_0000);

        // Two events of 60 on neuron 3 cross threshold 100 at the tick.
        wb_wr(R_CTRL, 32'h1);
        wb_wr(R_THRESH, 32'd100);
        wb_wr(R_EVENT, ev(3, 60));
        wb_wr(R_EVENT, ev(3, 60));
        wait_idle();
        rd_check("integ_pot3", pot_off(3), 32'd120);
        wb_wr(R_CTRL, 32'h3);
        wait_idle();
        rd_check("fire_pot3",  pot_off(3), 32'd0);
        rd_check("fire_spike", R_SPIKE, 32'h0000_0008);
        check("irq_disabled", {31'd0, irq}, 32'd0);
        rd_check("tick_selfclr", R_CTRL, 32'h1);
        wb_wr(R_CTRL, 32'h9);
        check("irq_enabled", {31'd0, irq}, 32'd1);
        wb_wr(R_CTRL, 32'h1);
        check("irq_off", {31'd0, irq}, 32'd0);

        // Tick written with four events queued: all integrate before leak/fire.
        wb_wr(R_CTRL, 32'h0);
        for (int i = 0; i < 4; i++) wb_wr(R_EVENT, ev(5, 30));
        rd_check("queued4_status", R_STATUS, 32'h0000_0400);
        b0 = busy_total;
        wb_wr(R_CTRL, 32'h3);
        wait_idle();
        check("busy_cycles", 32'(busy_total - b0), 32'(4 + NN));
        rd_check("ordered_pot5",  pot_off(5), 32'd0);
        rd_check("ordered_spike", R_SPIKE, 32'h0000_0020);

        // Overflow with enable low, then drain events whose index is out of range.
        wb_wr(R_CTRL, 32'h0);
        for (int i = 0; i < FD + 2; i++) wb_wr(R_EVENT, ev(NN + 4, 1));
        rd_check("ovf_status", R_STATUS, 32'h0000_080A);
        wb_wr(R_STATUS, 32'h8);
        rd_check("ovf_w1c", R_STATUS, 32'h0000_0802);
        wb_wr(R_CTRL, 32'h1);
        wait_idle();
        rd_check("drained_status", R_STATUS, 32'h0000_0004);
        rd_check("bad_idx_pot4", pot_off(4), 32'd0);

        // Unmapped offsets, read-only writes, byte enables and foreign base.
        rd_check("unmapped_18",  12'h018, 32'd0);
        rd_check("unmapped_pot", pot_off(NN), 32'd0);
        wb_wr(12'h018, 32'hDEAD_BEEF);
        wb_wr(pot_off(NN - 1), 32'h0000_1234);
        rd_check("pot_ro", pot_off(NN - 1), 32'd0);
        wb_xfer(1'b1, R_THRESH, 32'h1234_5678, 4'b0010, r);
        rd_check("thresh_bytesel", R_THRESH, 32'h0000_5664);
        wb_wr(R_THRESH, 32'd100);
        wb_wr(R_CTRL, 32'h0);
        wb_xfer(1'b1, R_EVENT, ev(1, 5), 4'h7, r);
        rd_check("event_partial_sel", R_STATUS, 32'h0000_0004);
        wb_wr(R_CTRL, 32'h1);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_1018;
        repeat (2) @(posedge clk); #1;
        check("foreign_no_ack", {31'd0, ack}, 32'd0);
        cyc = 1'b0; stb = 1'b0;

        // Integration saturates high; leak saturates low.
        wb_wr(R_EVENT, 32'h0070_0000);
        wb_wr(R_EVENT, 32'h0070_0000);
        wait_idle();
        rd_check("sat_hi_pot0", pot_off(0), 32'h0000_7FFF);
        wb_wr(R_LEAK, 32'h7FFF);
        rd_check("leak_rb", R_LEAK, 32'h0000_7FFF);
        wb_wr(R_CTRL, 32'h3);
        wait_idle();
        rd_check("leak1_pot0", pot_off(0), 32'h0000_0000);
        wb_wr(R_CTRL, 32'h3);
        wait_idle();
        rd_check("leak2_pot0", pot_off(0), 32'hFFFF_8001);
        rd_check("leak2_pot1", pot_off(1), 32'hFFFF_8000);
        wb_wr(R_CTRL, 32'h3);
        wait_idle();
        rd_check("leak3_pot0", pot_off(0), 32'hFFFF_8000);
        rd_check("leak_spike", R_SPIKE, 32'd0);

        wb_wr(R_CTRL, 32'h5);
        wait_idle();
        rd_check("clear_pot0", pot_off(0), 32'd0);
        rd_check("clear_pot1", pot_off(1), 32'd0);

        // Reset in the middle of leak/fire.
        wb_wr(R_LEAK, 32'd0);
        wb_wr(R_EVENT, ev(0, 200));
        wb_wr(R_EVENT, ev(10, 50));
        wait_idle();
        rd_check("pre_rst_pot10", pot_off(10), 32'd50);
        wb_wr(R_CTRL, 32'hB);
        repeat (3) @(posedge clk); #1;
        check("midtick_irq", {31'd0, irq}, 32'd1);
        rst = 1'b0;
        #1;
        check("async_rst_irq", {31'd0, irq}, 32'd0);
        check("async_rst_ack", {31'd0, ack}, 32'd0);
        check("async_rst_dat", dat_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        rd_check("post_rst_status", R_STATUS, 32'h0000_0004);
        rd_check("post_rst_ctrl",   R_CTRL,   32'h0000_0000);
        rd_check("post_rst_thresh", R_THRESH, 32'h0000_7FFF);
        rd_check("post_rst_pot10",  pot_off(10), 32'd0);
        rd_check("post_rst_spike",  R_SPIKE, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
